// File: rtl/relobi_rsp_decoder.sv
// relobi_rsp_decoder: manager-side receiver for the reliable OBI R channel.
// Decodes and corrects Hsiao SEC-DED protected rdata and r_other
// ({err, rid, r_optional}). Corrected beats are buffered in a 2-entry
// registered FIFO and presented as a plain OBI response. Corrected and
// uncorrectable beats are counted for the status register file.
//
// Ports:
//   clk_i, rst_i           clock, asynchronous active-high reset
//   rvalid_i / rready_o    relOBI response handshake
//   rdata_i, rother_i      encoded payloads, ECC in the MSBs
//   rvalid_o / rready_i    OBI response handshake
//   rdata_o, err_o, rid_o, ropt_o   corrected response fields
//   ce_o, ue_o             corrected / uncorrectable flags of the head beat
//   clear_i                synchronous clear of counters and capture
//   ce_cnt_o, ue_cnt_o     saturating event counters
//
// Optional macro RELOBI_RSP_DEC_ERR_CAPTURE_EN adds first-uncorrectable
// capture outputs: cap_valid_o, cap_rid_o, cap_data_syn_o, cap_other_syn_o.
//
// H matrix: check bits use identity columns; payload bit i uses the i-th
// odd-weight (>=3) column, enumerated by weight and then ascending value.

module relobi_rsp_decoder #(
  parameter int unsigned DataWidth     = 32,
  parameter int unsigned IdWidth       = 1,
  parameter int unsigned ROptWidth     = 1,
  parameter int unsigned OtherWidth    = 1 + IdWidth + ROptWidth,
  // Smallest r with 2^(r-1) >= k + r (SEC-DED Hsiao bound).
  parameter int unsigned DataEccWidth  =
      (DataWidth + 2 <= 2)   ? 2 : (DataWidth + 3 <= 4)   ? 3 :
      (DataWidth + 4 <= 8)   ? 4 : (DataWidth + 5 <= 16)  ? 5 :
      (DataWidth + 6 <= 32)  ? 6 : (DataWidth + 7 <= 64)  ? 7 :
      (DataWidth + 8 <= 128) ? 8 : (DataWidth + 9 <= 256) ? 9 :
      (DataWidth + 10 <= 512) ? 10 : 11,
  parameter int unsigned OtherEccWidth =
      (OtherWidth + 2 <= 2)   ? 2 : (OtherWidth + 3 <= 4)   ? 3 :
      (OtherWidth + 4 <= 8)   ? 4 : (OtherWidth + 5 <= 16)  ? 5 :
      (OtherWidth + 6 <= 32)  ? 6 : (OtherWidth + 7 <= 64)  ? 7 :
      (OtherWidth + 8 <= 128) ? 8 : (OtherWidth + 9 <= 256) ? 9 :
      (OtherWidth + 10 <= 512) ? 10 : 11,
  parameter int unsigned CntWidth      = 16
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                rvalid_i,
  output logic                                rready_o,
  input  logic [DataWidth+DataEccWidth-1:0]   rdata_i,
  input  logic [OtherWidth+OtherEccWidth-1:0] rother_i,
  output logic                                rvalid_o,
  input  logic                                rready_i,
  output logic [DataWidth-1:0]                rdata_o,
  output logic                                err_o,
  output logic [IdWidth-1:0]                  rid_o,
  output logic [ROptWidth-1:0]                ropt_o,
  output logic                                ce_o,
  output logic                                ue_o,
  input  logic                                clear_i,
  output logic [CntWidth-1:0]                 ce_cnt_o,
  output logic [CntWidth-1:0]                 ue_cnt_o
`ifdef RELOBI_RSP_DEC_ERR_CAPTURE_EN
  ,
  output logic                                cap_valid_o,
  output logic [IdWidth-1:0]                  cap_rid_o,
  output logic [DataEccWidth-1:0]             cap_data_syn_o,
  output logic [OtherEccWidth-1:0]            cap_other_syn_o
`endif
);

  localparam int unsigned EntryWidth = DataWidth + 1 + IdWidth + ROptWidth + 2;

  // Payload column idx of an r-bit Hsiao H matrix.
  function automatic int unsigned hsiao_col(int unsigned idx, int unsigned r);
    int unsigned n;
    int unsigned res;
    logic        found;
    n     = 0;
    res   = 0;
    found = 1'b0;
    for (int unsigned w = 3; w <= r; w += 2) begin
      for (int unsigned v = 1; v < (32'd1 << r); v++) begin
        if (!found && ($countones(v) == int'(w))) begin
          if (n == idx) begin
            res   = v;
            found = 1'b1;
          end
          n++;
        end
      end
    end
    return res;
  endfunction

  logic [DataEccWidth-1:0]  dcol [DataWidth];
  logic [OtherEccWidth-1:0] ocol [OtherWidth];

  for (genvar i = 0; i < DataWidth; i++) begin : g_dcol
    localparam int unsigned Col = hsiao_col(i, DataEccWidth);
    assign dcol[i] = DataEccWidth'(Col);
  end

  for (genvar i = 0; i < OtherWidth; i++) begin : g_ocol
    localparam int unsigned Col = hsiao_col(i, OtherEccWidth);
    assign ocol[i] = OtherEccWidth'(Col);
  end

  // ---------------- input-side decode ----------------
  logic [DataWidth-1:0]     data_raw, data_fix;
  logic [DataEccWidth-1:0]  data_calc, data_syn;
  logic                     data_single, data_ue;
  logic [OtherWidth-1:0]    other_raw, other_fix;
  logic [OtherEccWidth-1:0] other_calc, other_syn;
  logic                     other_single, other_ue;

  assign data_raw  = rdata_i[DataWidth-1:0];
  assign other_raw = rother_i[OtherWidth-1:0];

  // rdata syndrome and correction
  always_comb begin
    data_calc   = '0;
    data_fix    = data_raw;
    data_single = 1'b0;
    data_ue     = 1'b0;
    for (int unsigned i = 0; i < DataWidth; i++) begin
      if (data_raw[i]) data_calc = data_calc ^ dcol[i];
    end
    data_syn = data_calc ^ rdata_i[DataWidth +: DataEccWidth];
    if (data_syn != '0) begin
      // weight-1 syndrome is a flipped check bit: payload already correct
      if ($countones(data_syn) == 1) data_single = 1'b1;
      for (int unsigned i = 0; i < DataWidth; i++) begin
        if (data_syn == dcol[i]) begin
          data_fix[i] = ~data_raw[i];
          data_single = 1'b1;
        end
      end
      data_ue = ~data_single;
    end
  end

  // r_other syndrome and correction
  always_comb begin
    other_calc   = '0;
    other_fix    = other_raw;
    other_single = 1'b0;
    other_ue     = 1'b0;
    for (int unsigned i = 0; i < OtherWidth; i++) begin
      if (other_raw[i]) other_calc = other_calc ^ ocol[i];
    end
    other_syn = other_calc ^ rother_i[OtherWidth +: OtherEccWidth];
    if (other_syn != '0) begin
      if ($countones(other_syn) == 1) other_single = 1'b1;
      for (int unsigned i = 0; i < OtherWidth; i++) begin
        if (other_syn == ocol[i]) begin
          other_fix[i] = ~other_raw[i];
          other_single = 1'b1;
        end
      end
      other_ue = ~other_single;
    end
  end

  logic                  beat_ce, beat_ue;
  logic [EntryWidth-1:0] entry_in;

  assign beat_ue  = data_ue | other_ue;
  assign beat_ce  = (data_single | other_single) & ~beat_ue;
  assign entry_in = {data_fix,
                     other_fix[OtherWidth-1] | beat_ue,
                     other_fix[ROptWidth +: IdWidth],
                     other_fix[ROptWidth-1:0],
                     beat_ce,
                     beat_ue};

  // ---------------- 2-entry FIFO ----------------
  logic [EntryWidth-1:0] mem_q [2];
  logic [EntryWidth-1:0] mem_d [2];
  logic                  rptr_q, rptr_d, wptr_q, wptr_d;
  logic [1:0]            cnt_q, cnt_d;
  logic                  push, pop;

  assign rready_o = (cnt_q != 2'd2);
  assign rvalid_o = (cnt_q != 2'd0);
  assign push     = rvalid_i & rready_o;
  assign pop      = rvalid_o & rready_i;

  // Popped slots are zeroed so an empty FIFO presents all-zero outputs.
  always_comb begin
    mem_d  = mem_q;
    rptr_d = rptr_q;
    wptr_d = wptr_q;
    cnt_d  = cnt_q;
    if (pop) begin
      mem_d[rptr_q] = '0;
      rptr_d        = ~rptr_q;
    end
    if (push) begin
      mem_d[wptr_q] = entry_in;
      wptr_d        = ~wptr_q;
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rptr_q   <= 1'b0;
      wptr_q   <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      mem_q[0] <= mem_d[0];
      mem_q[1] <= mem_d[1];
      rptr_q   <= rptr_d;
      wptr_q   <= wptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign {rdata_o, err_o, rid_o, ropt_o, ce_o, ue_o} = mem_q[rptr_q];

  // ---------------- saturating event counters ----------------
  logic [CntWidth-1:0] ce_cnt_q, ce_cnt_d, ue_cnt_q, ue_cnt_d;

  always_comb begin
    ce_cnt_d = ce_cnt_q;
    ue_cnt_d = ue_cnt_q;
    if (clear_i) begin
      ce_cnt_d = '0;
      ue_cnt_d = '0;
    end else if (push) begin
      if (beat_ce && (ce_cnt_q != '1)) ce_cnt_d = ce_cnt_q + CntWidth'(1);
      if (beat_ue && (ue_cnt_q != '1)) ue_cnt_d = ue_cnt_q + CntWidth'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ce_cnt_q <= '0;
      ue_cnt_q <= '0;
    end else begin
      ce_cnt_q <= ce_cnt_d;
      ue_cnt_q <= ue_cnt_d;
    end
  end

  assign ce_cnt_o = ce_cnt_q;
  assign ue_cnt_o = ue_cnt_q;

`ifdef RELOBI_RSP_DEC_ERR_CAPTURE_EN
  // ---------------- first-uncorrectable capture ----------------
  logic                     cap_valid_q, cap_valid_d;
  logic [IdWidth-1:0]       cap_rid_q, cap_rid_d;
  logic [DataEccWidth-1:0]  cap_dsyn_q, cap_dsyn_d;
  logic [OtherEccWidth-1:0] cap_osyn_q, cap_osyn_d;

  always_comb begin
    cap_valid_d = cap_valid_q;
    cap_rid_d   = cap_rid_q;
    cap_dsyn_d  = cap_dsyn_q;
    cap_osyn_d  = cap_osyn_q;
    if (clear_i) begin
      cap_valid_d = 1'b0;
      cap_rid_d   = '0;
      cap_dsyn_d  = '0;
      cap_osyn_d  = '0;
    end else if (push && beat_ue && !cap_valid_q) begin
      cap_valid_d = 1'b1;
      cap_rid_d   = other_raw[ROptWidth +: IdWidth];
      cap_dsyn_d  = data_syn;
      cap_osyn_d  = other_syn;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cap_valid_q <= 1'b0;
      cap_rid_q   <= '0;
      cap_dsyn_q  <= '0;
      cap_osyn_q  <= '0;
    end else begin
      cap_valid_q <= cap_valid_d;
      cap_rid_q   <= cap_rid_d;
      cap_dsyn_q  <= cap_dsyn_d;
      cap_osyn_q  <= cap_osyn_d;
    end
  end

  assign cap_valid_o     = cap_valid_q;
  assign cap_rid_o       = cap_rid_q;
  assign cap_data_syn_o  = cap_dsyn_q;
  assign cap_other_syn_o = cap_osyn_q;
`endif

endmodule

// File: tb/tb_relobi_rsp_decoder.sv
// Directed self-checking bench for relobi_rsp_decoder (CntWidth=2 so that
// counter saturation is reachable quickly). Encodes beats with a locally
// tabulated Hsiao H matrix; expected values are hand-computed.

module tb_relobi_rsp_decoder;

  localparam int unsigned CW = 2;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        rvalid_i;
  logic        rready_o;
  logic [38:0] rdata_i;
  logic [6:0]  rother_i;
  logic        rvalid_o;
  logic        rready_i;
  logic [31:0] rdata_o;
  logic        err_o;
  logic [0:0]  rid_o;
  logic [0:0]  ropt_o;
  logic        ce_o;
  logic        ue_o;
  logic        clear_i;
  logic [CW-1:0] ce_cnt_o;
  logic [CW-1:0] ue_cnt_o;
`ifdef RELOBI_RSP_DEC_ERR_CAPTURE_EN
  logic        cap_valid_o;
  logic [0:0]  cap_rid_o;
  logic [6:0]  cap_data_syn_o;
  logic [3:0]  cap_other_syn_o;
`endif

  relobi_rsp_decoder #(.CntWidth(CW)) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .rvalid_i (rvalid_i),
    .rready_o (rready_o),
    .rdata_i  (rdata_i),
    .rother_i (rother_i),
    .rvalid_o (rvalid_o),
    .rready_i (rready_i),
    .rdata_o  (rdata_o),
    .err_o    (err_o),
    .rid_o    (rid_o),
    .ropt_o   (ropt_o),
    .ce_o     (ce_o),
    .ue_o     (ue_o),
    .clear_i  (clear_i),
    .ce_cnt_o (ce_cnt_o),
    .ue_cnt_o (ue_cnt_o)
`ifdef RELOBI_RSP_DEC_ERR_CAPTURE_EN
    ,
    .cap_valid_o     (cap_valid_o),
    .cap_rid_o       (cap_rid_o),
    .cap_data_syn_o  (cap_data_syn_o),
    .cap_other_syn_o (cap_other_syn_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  // Weight-3 columns of a 7-bit and a 4-bit code, ascending value.
  int unsigned dcol_t [32] = '{7, 11, 13, 14, 19, 21, 22, 25, 26, 28,
                               35, 37, 38, 41, 42, 44, 49, 50, 52, 56,
                               67, 69, 70, 73, 74, 76, 81, 82, 84, 88,
                               97, 98};
  int unsigned ocol_t [3]  = '{7, 11, 13};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [38:0] enc_data(input logic [31:0] d);
    logic [6:0] e;
    e = '0;
    for (int i = 0; i < 32; i++) if (d[i]) e = e ^ 7'(dcol_t[i]);
    return {e, d};
  endfunction

  function automatic logic [6:0] enc_other(input logic [2:0] o);
    logic [3:0] e;
    e = '0;
    for (int i = 0; i < 3; i++) if (o[i]) e = e ^ 4'(ocol_t[i]);
    return {e, o};
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic [31:0] d, input logic [2:0] o,
                       input logic [38:0] dflip, input logic [6:0] oflip);
    rdata_i  = enc_data(d) ^ dflip;
    rother_i = enc_other(o) ^ oflip;
    rvalid_i = 1'b1;
  endtask

  // Present a beat and hold it until the DUT accepts it (bounded).
  task automatic send(input logic [31:0] d, input logic [2:0] o,
                      input logic [38:0] dflip, input logic [6:0] oflip);
    logic acc;
    int   n;
    drive(d, o, dflip, oflip);
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 8) begin
      acc = rready_o;
      tick();
      n++;
    end
    rvalid_i = 1'b0;
    if (!acc) check("accept_timeout", 64'(acc), 64'(1));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    rst_i    = 1'b1;
    rvalid_i = 1'b0;
    rready_i = 1'b1;
    clear_i  = 1'b0;
    rdata_i  = '0;
    rother_i = '0;
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_rvalid", 64'(rvalid_o), 64'(0));
    check("rst_rready", 64'(rready_o), 64'(1));
    check("rst_rdata",  64'(rdata_o),  64'(0));
    check("rst_flags",  64'({err_o, rid_o, ropt_o, ce_o, ue_o}), 64'(0));
    check("rst_cnts",   64'({ce_cnt_o, ue_cnt_o}), 64'(0));
    rst_i = 1'b0;
    tick();

    // clean beat
    send(32'hDEADBEEF, 3'b010, '0, '0);
    check("clean_rvalid", 64'(rvalid_o), 64'(1));
    check("clean_rdata",  64'(rdata_o),  64'hDEADBEEF);
    check("clean_rid",    64'(rid_o),    64'(1));
    check("clean_err",    64'(err_o),    64'(0));
    check("clean_ce_ue",  64'({ce_o, ue_o}), 64'(0));
    check("clean_cnts",   64'({ce_cnt_o, ue_cnt_o}), 64'(0));
    tick();
    check("clean_drained", 64'(rvalid_o), 64'(0));

    // single data flip, bit 5
    send(32'h12345678, 3'b000, 39'd1 << 5, '0);
    check("sgl_rdata",  64'(rdata_o),  64'h12345678);
    check("sgl_ce",     64'(ce_o),     64'(1));
    check("sgl_ue",     64'(ue_o),     64'(0));
    check("sgl_err",    64'(err_o),    64'(0));
    check("sgl_cecnt",  64'(ce_cnt_o), 64'(1));
    tick();

    // double data flip, bits 0 and 1: raw payload passes through
    send(32'hA5A5A5A5, 3'b000, 39'h3, '0);
    check("dbl_ue",     64'(ue_o),     64'(1));
    check("dbl_ce",     64'(ce_o),     64'(0));
    check("dbl_err",    64'(err_o),    64'(1));
    check("dbl_rdata",  64'(rdata_o),  64'hA5A5A5A6);
    check("dbl_uecnt",  64'(ue_cnt_o), 64'(1));
    check("dbl_cecnt",  64'(ce_cnt_o), 64'(1));
`ifdef RELOBI_RSP_DEC_ERR_CAPTURE_EN
    check("cap_valid",  64'(cap_valid_o),     64'(1));
    check("cap_dsyn",   64'(cap_data_syn_o),  64'h0C);
    check("cap_osyn",   64'(cap_other_syn_o), 64'(0));
    check("cap_rid",    64'(cap_rid_o),       64'(0));
`endif
    tick();

    // single flip of the rid payload bit
    send(32'h000000FF, 3'b001, '0, 7'b0000010);
    check("osgl_rid",   64'(rid_o),    64'(0));
    check("osgl_ropt",  64'(ropt_o),   64'(1));
    check("osgl_ce",    64'(ce_o),     64'(1));
    check("osgl_cecnt", 64'(ce_cnt_o), 64'(2));
    tick();

    // double flip in r_other (rid and err): uncorrectable, raw passes
    send(32'h00000011, 3'b000, '0, 7'b0000110);
    check("odbl_rid",   64'(rid_o),    64'(1));
    check("odbl_err",   64'(err_o),    64'(1));
    check("odbl_ue",    64'(ue_o),     64'(1));
    check("odbl_uecnt", 64'(ue_cnt_o), 64'(2));
`ifdef RELOBI_RSP_DEC_ERR_CAPTURE_EN
    check("cap_frozen_rid",  64'(cap_rid_o),       64'(0));
    check("cap_frozen_osyn", 64'(cap_other_syn_o), 64'(0));
`endif
    tick();

    // flipped data check bit
    send(32'hCAFEF00D, 3'b000, 39'd1 << 34, '0);
    check("eccbit_rdata", 64'(rdata_o),  64'hCAFEF00D);
    check("eccbit_ce",    64'(ce_o),     64'(1));
    check("eccbit_cecnt", 64'(ce_cnt_o), 64'(3));
    tick();

    // backpressure: A, B fill the FIFO, C waits
    rready_i = 1'b0;
    drive(32'h0A0A0A0A, 3'b000, '0, '0);
    tick();
    check("bp_rready_1", 64'(rready_o), 64'(1));
    check("bp_head_a",   64'(rdata_o),  64'h0A0A0A0A);
    drive(32'h0B0B0B0B, 3'b010, '0, '0);
    tick();
    check("bp_rready_2", 64'(rready_o), 64'(0));
    drive(32'h0C0C0C0C, 3'b000, '0, '0);
    tick();
    check("bp_held",     64'(rready_o), 64'(0));
    check("bp_still_a",  64'(rdata_o),  64'h0A0A0A0A);
    rready_i = 1'b1;
    tick();
    check("bp_head_b",   64'(rdata_o),  64'h0B0B0B0B);
    check("bp_rid_b",    64'(rid_o),    64'(1));
    check("bp_rready_3", 64'(rready_o), 64'(1));
    tick();
    rvalid_i = 1'b0;
    check("bp_head_c",   64'(rdata_o),  64'h0C0C0C0C);
    check("bp_valid_c",  64'(rvalid_o), 64'(1));
    tick();
    check("bp_empty",    64'(rvalid_o), 64'(0));
    check("bp_cnts",     64'({ce_cnt_o, ue_cnt_o}), 64'({2'd3, 2'd2}));

    // clear
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    check("clr_cnts", 64'({ce_cnt_o, ue_cnt_o}), 64'(0));
`ifdef RELOBI_RSP_DEC_ERR_CAPTURE_EN
    check("clr_cap", 64'({cap_valid_o, cap_rid_o, cap_data_syn_o, cap_other_syn_o}), 64'(0));
`endif

    // saturation: five corrected beats
    send(32'h11111111, 3'b000, 39'd1 << 3,  '0); tick();
    send(32'h22222222, 3'b000, 39'd1 << 9,  '0); tick();
    check("sat_two", 64'(ce_cnt_o), 64'(2));
    send(32'h33333333, 3'b000, 39'd1 << 17, '0); tick();
    send(32'h44444444, 3'b000, 39'd1 << 30, '0); tick();
    send(32'h55555555, 3'b000, 39'd1 << 36, '0);
    check("sat_rdata", 64'(rdata_o),  64'h55555555);
    check("sat_ce",    64'(ce_cnt_o), 64'(3));
    check("sat_ue",    64'(ue_cnt_o), 64'(0));
    tick();

    // clear together with a corrected push: clear wins, FIFO untouched
    clear_i = 1'b1;
    send(32'h66666666, 3'b000, 39'd1 << 7, '0);
    clear_i = 1'b0;
    check("clrpush_cecnt", 64'(ce_cnt_o), 64'(0));
    check("clrpush_ce",    64'(ce_o),     64'(1));
    check("clrpush_rdata", 64'(rdata_o),  64'h66666666);
    tick();

`ifdef RELOBI_RSP_DEC_ERR_CAPTURE_EN
    // clear together with an uncorrectable push: nothing captured
    clear_i = 1'b1;
    send(32'h77777777, 3'b000, 39'h3, '0);
    clear_i = 1'b0;
    check("clrue_cap",   64'(cap_valid_o), 64'(0));
    check("clrue_uecnt", 64'(ue_cnt_o),    64'(0));
    check("clrue_ue",    64'(ue_o),        64'(1));
    tick();
`endif

    // async reset with two beats buffered
    rready_i = 1'b0;
    send(32'h88888888, 3'b000, '0, '0);
    send(32'h99999999, 3'b000, '0, '0);
    check("prerst_valid", 64'(rvalid_o), 64'(1));
    check("prerst_ready", 64'(rready_o), 64'(0));
    rst_i = 1'b1;
    #1;
    check("arst_valid", 64'(rvalid_o), 64'(0));
    check("arst_ready", 64'(rready_o), 64'(1));
    check("arst_rdata", 64'(rdata_o),  64'(0));
    @(posedge clk_i);
    #3;
    rst_i    = 1'b0;
    rready_i = 1'b1;
    tick();
    check("postrst_valid_1", 64'(rvalid_o), 64'(0));
    tick();
    check("postrst_valid_2", 64'(rvalid_o), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/relobi_rsp_decoder.md
Name: relobi_rsp_decoder

Overview:
- Manager-side receiver for the reliable OBI (relOBI) R channel.
- Accepts a Hsiao SEC-DED protected response: rdata with its ECC, and the packed r_other field (err, rid, r_optional) with its ECC.
- Decodes and corrects both fields, buffers beats in a 2-entry registered FIFO, and presents a plain OBI response to the manager.
- Counts corrected and uncorrectable events for the safety/status register file.

Parameters:
- DataWidth, 32, rdata payload width.
- IdWidth, 1, rid width.
- ROptWidth, 1, r_optional width (already max(1, ...) resolved by the caller).
- OtherWidth, 1+IdWidth+ROptWidth, packed r_other payload width; order MSB→LSB is {err, rid, r_optional}.
- DataEccWidth, hsiao_ecc_pkg::min_ecc(DataWidth) = 7 at default.
- OtherEccWidth, hsiao_ecc_pkg::min_ecc(OtherWidth) = 4 at default.
- CntWidth, 16, width of the error counters.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; asynchronous, active-high.
- rvalid_i  in  1  relOBI response valid.
- rready_o  out  1  relOBI response ready.
- rdata_i  in  DataWidth+DataEccWidth  encoded rdata, ECC in the MSBs.
- rother_i  in  OtherWidth+OtherEccWidth  encoded r_other, ECC in the MSBs.
- rvalid_o  out  1  OBI response valid.
- rready_i  in  1  OBI response ready.
- rdata_o  out  DataWidth  corrected rdata.
- err_o  out  1  corrected err, OR-ed with this beat's uncorrectable flag.
- rid_o  out  IdWidth  corrected rid.
- ropt_o  out  ROptWidth  corrected r_optional.
- ce_o  out  1  current output beat had ≥1 corrected single-bit error.
- ue_o  out  1  current output beat had ≥1 uncorrectable error.
- clear_i  in  1  synchronous clear of counters and capture.
- ce_cnt_o  out  CntWidth  corrected-beat counter.
- ue_cnt_o  out  CntWidth  uncorrectable-beat counter.

Behaviour:
- Reset (async): FIFO empty, both counters 0. Outputs: rvalid_o=0, rready_o=1; rdata_o/err_o/rid_o/ropt_o/ce_o/ue_o=0 (outputs are driven from the head entry, and cleared entries read 0).
- Decode is combinational on the input side and independent per field.
  - Syndrome 0: no error.
  - Odd-weight syndrome matching a column: single error, bit flipped.
  - Any other non-zero syndrome: uncorrectable; raw payload bits passed through.
- Per-beat flags:
  - ce = (data single) | (other single), when no uncorrectable is present.
  - ue = (data uncorrectable) | (other uncorrectable).
  - ue takes precedence: ce is forced 0 when ue=1.
- FIFO: 2 entries; each stores {rdata, err|ue, rid, ropt, ce, ue}.
  - rready_o = !full. Registered; no combinational path from rready_i.
  - Push on rvalid_i & rready_o. Pop on rvalid_o & rready_i.
  - Latency: a beat pushed at edge N is visible on rvalid_o after edge N (1 cycle).
  - Simultaneous push and pop at count=1: count stays 1, order preserved.
  - When full, rready_o=0 even if a pop occurs that cycle.
  - Response order is strictly preserved.
- Counters increment once per pushed beat: ce_cnt_o when ce=1, ue_cnt_o when ue=1.
  - Both saturate at 2^CntWidth-1; no wrap.
  - clear_i zeroes both counters. clear_i wins over a same-cycle increment.
  - clear_i does not affect FIFO contents.
- rvalid_i held while rready_o=0 is legal; input payload must be stable until accepted.
- Reset mid-transfer discards buffered beats; no partial beat is ever output.

Optional Feature:
- Macro: RELOBI_RSP_DEC_ERR_CAPTURE_EN.
- Defined, adds outputs:
  - cap_valid_o (1)
  - cap_rid_o (IdWidth)
  - cap_data_syn_o (DataEccWidth)
  - cap_other_syn_o (OtherEccWidth)
- Capture fires on the first pushed beat with ue=1 after reset or clear_i. Stored values are the raw rid and both syndromes; cap_valid_o is set to 1.
- Capture is then frozen until clear_i or rst_i, both of which zero all capture outputs.
- If clear_i coincides with a ue push, clear wins and nothing is captured.
- Undefined: the capture ports and registers do not exist; all other behaviour is identical.

Test Plan:
- Clean beat: rdata=0xDEADBEEF, err=0, rid=1, properly encoded; rready_i=1.
  - rvalid_o one cycle after accept, rdata_o=0xDEADBEEF, rid_o=1, ce_o=ue_o=0, counters 0.
- Single flip of rdata bit 5 on 0x12345678.
  - rdata_o=0x12345678, ce_o=1, ce_cnt_o=1, err_o=0.
- Double flip (rdata bits 0 and 1).
  - ue_o=1, err_o=1, ue_cnt_o=1, ce_cnt_o unchanged.
  - With capture enabled: cap_valid_o=1 and cap_data_syn_o equals the XOR of the H columns for bits 0 and 1.
- Backpressure: rready_i=0, push 3 beats back-to-back.
  - rready_o drops after the 2nd accept and the 3rd beat is held.
  - Releasing rready_i drains beats in order A, B, C.
- Counter saturation with CntWidth=2: 5 corrected beats → ce_cnt_o=3.
  - Then clear_i together with a corrected push → ce_cnt_o=0.
- Async reset asserted with 2 beats buffered.
  - rvalid_o=0 and rready_o=1 immediately; no stale beat after deassert.
